// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the decode/execute boundary: register-file geometry,
// default widths and the ID/EX pipeline register layout.
package rv_pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN_DEF   = 32;
    localparam int CTRL_W_DEF = 16;
    localparam int CNT_W_DEF  = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  rd_wen;
        logic [31:0]           pc;
        logic [XLEN_DEF-1:0]   imm;
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [XLEN_DEF-1:0]   op1;
        logic [XLEN_DEF-1:0]   op2;
    } idex_t;

    // x0 is hardwired to zero and never tracked.
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] r);
        return r == '0;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters with source/destination lookups.
// RF_BYPASS_EN: when defined, reports a bypass hit for a source whose last outstanding write is on the writeback port.
module reg_scoreboard
    import rv_pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  inc_en,
    input  logic [REG_ADDR_W-1:0] inc_idx,
    input  logic                  dec_en,
    input  logic [REG_ADDR_W-1:0] dec_idx,
    input  logic [REG_ADDR_W-1:0] rs1_idx,
    input  logic [REG_ADDR_W-1:0] rs2_idx,
    input  logic [REG_ADDR_W-1:0] rd_idx,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rs1_byp,
    output logic                  rs2_byp,
    output logic                  rd_full
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt_d;

    assign cnt_d[0] = '0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            logic inc;
            logic dec;
            assign inc = inc_en && (inc_idx == REG_ADDR_W'(gi));
            assign dec = dec_en && (dec_idx == REG_ADDR_W'(gi));
            // A stray decrement of an idle register saturates at zero.
            assign cnt_d[gi] = flush                              ? '0 :
                               (inc && !dec)                      ? cnt_q[gi] + CNT_ONE :
                               (dec && !inc && cnt_q[gi] != '0)   ? cnt_q[gi] - CNT_ONE :
                                                                    cnt_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rs1_busy = cnt_q[rs1_idx] != '0;
    assign rs2_busy = cnt_q[rs2_idx] != '0;
    assign rd_full  = cnt_q[rd_idx] == CNT_MAX;

`ifdef RF_BYPASS_EN
    assign rs1_byp = dec_en && (dec_idx == rs1_idx) && (cnt_q[rs1_idx] == CNT_ONE);
    assign rs2_byp = dec_en && (dec_idx == rs2_idx) && (cnt_q[rs2_idx] == CNT_ONE);
`else
    assign rs1_byp = 1'b0;
    assign rs2_byp = 1'b0;
`endif

    property p_no_dec_underflow;
        @(posedge clk) disable iff (reset)
            !(dec_en && !is_x0(dec_idx) && !flush && cnt_q[dec_idx] == '0 &&
              !(inc_en && inc_idx == dec_idx));
    endproperty
    a_no_dec_underflow: assert property (p_no_dec_underflow);

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: RF address drive, writeback bypass, scoreboard interlock and the ID/EX register.
// RF_BYPASS_EN: when defined, a reader may issue in the same cycle as the last writeback of its source.
module operand_fetch_stage
    import rv_pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic                  in_rs1_en,
    input  logic                  in_rs2_en,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic [31:0]           in_pc,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [CTRL_W-1:0]     in_ctrl,
    output logic [REG_ADDR_W-1:0] rf_raddr1,
    output logic [REG_ADDR_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2,
    input  logic                  wb_wen,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_op1,
    output logic [XLEN-1:0]       out_op2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_rd_wen,
    output logic [31:0]           out_pc,
    output logic [XLEN-1:0]       out_imm,
    output logic [CTRL_W-1:0]     out_ctrl
);

    logic rs1_busy, rs2_busy, rs1_byp, rs2_byp, rd_full;
    logic haz_rs1, haz_rs2, haz_rd, hazard, fire;
    logic [XLEN-1:0] op1, op2;

    logic  out_valid_q, out_valid_d;
    idex_t idex_q, idex_d;

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    reg_scoreboard #(
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .inc_en   (fire && in_rd_wen && !is_x0(in_rd)),
        .inc_idx  (in_rd),
        .dec_en   (wb_wen && !is_x0(wb_rd)),
        .dec_idx  (wb_rd),
        .rs1_idx  (in_rs1),
        .rs2_idx  (in_rs2),
        .rd_idx   (in_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rs1_byp  (rs1_byp),
        .rs2_byp  (rs2_byp),
        .rd_full  (rd_full)
    );

    assign haz_rs1 = in_rs1_en && !is_x0(in_rs1) && rs1_busy && !rs1_byp;
    assign haz_rs2 = in_rs2_en && !is_x0(in_rs2) && rs2_busy && !rs2_byp;
    assign haz_rd  = in_rd_wen && !is_x0(in_rd) && rd_full;
    assign hazard  = haz_rs1 || haz_rs2 || haz_rd;

    assign in_ready = !flush && (!out_valid_q || out_ready) && !hazard;
    assign fire     = in_valid && in_ready;

    // The RF has no internal write-through, so same-cycle writeback data is steered in here.
    assign op1 = is_x0(in_rs1) ? '0 : (rs1_byp ? wb_data : rf_rdata1);
    assign op2 = is_x0(in_rs2) ? '0 : (rs2_byp ? wb_data : rf_rdata2);

    always_comb begin
        out_valid_d = out_valid_q;
        idex_d      = idex_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d   = 1'b1;
            idex_d.rd     = in_rd;
            idex_d.rd_wen = in_rd_wen;
            idex_d.pc     = in_pc;
            idex_d.imm    = in_imm;
            idex_d.ctrl   = in_ctrl;
            idex_d.op1    = op1;
            idex_d.op2    = op2;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            idex_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            idex_q      <= idex_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_op1    = idex_q.op1;
    assign out_op2    = idex_q.op2;
    assign out_rd     = idex_q.rd;
    assign out_rd_wen = idex_q.rd_wen;
    assign out_pc     = idex_q.pc;
    assign out_imm    = idex_q.imm;
    assign out_ctrl   = idex_q.ctrl;

endmodule
